// File: rtl/aes_core_scheduler.sv
// aes_core_scheduler
// Shares one AES encryption core between two requesters using round-robin
// arbitration. Each operation is captured, run on the core, returned as a
// response tagged with the requester id, and followed by a recovery gap.
// A watchdog aborts an operation whose core never reports valid.
//
// Ports:
//   AES_clk, AES_rst_n          clock, synchronous active-low reset
//   reqN_valid/ready/data/key   requester N block handshake (N = 0, 1)
//   rsp_valid/ready/id/data/err result handshake, err = timeout abort
//   core_en/data_in/key_in      drive to the AES core
//   core_data_out(_valid)       result from the AES core
//   busy                        scheduler not idle
//
// state  | meaning
// IDLE   | waiting for a request, grant is combinational
// RUN    | core_en high, waiting for core valid or watchdog
// RESP   | response held until consumer accepts
// GAP    | core_en low for GAP_CYC cycles before next grant
module aes_core_scheduler #(
  parameter int TIMEOUT_CYC = 64,
  parameter int GAP_CYC     = 2
) (
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_data,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_data,
  input  logic [127:0] req1_key,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic         core_en,
  output logic [127:0] core_data_in,
  output logic [127:0] core_key_in,
  input  logic [127:0] core_data_out,
  input  logic         core_data_out_valid,
  output logic         busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam logic [7:0] RUN_LAST = 8'(TIMEOUT_CYC - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

  logic [1:0] state;
  logic       last_grant;
  logic [7:0] run_cnt;
  logic [3:0] gap_cnt;
  logic       grant_any;
  logic       grant_id;
  logic       take;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  end

  assign take       = (state == S_IDLE) && grant_any;
  assign req0_ready = take && !grant_id;
  assign req1_ready = take && grant_id;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge AES_clk) begin
    if (!AES_rst_n) begin
      state        <= S_IDLE;
      last_grant   <= 1'b1;
      run_cnt      <= '0;
      gap_cnt      <= '0;
      core_en      <= 1'b0;
      core_data_in <= '0;
      core_key_in  <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take) begin
            core_data_in <= grant_id ? req1_data : req0_data;
            core_key_in  <= grant_id ? req1_key  : req0_key;
            rsp_id       <= grant_id;
            last_grant   <= grant_id;
            run_cnt      <= '0;
            core_en      <= 1'b1;
            state        <= S_RUN;
          end
        end
        S_RUN: begin
          // Core valid takes priority over a watchdog expiry in the same cycle.
          if (core_data_out_valid) begin
            rsp_data  <= core_data_out;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            core_en   <= 1'b0;
            state     <= S_RESP;
          end else if (run_cnt == RUN_LAST) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            core_en   <= 1'b0;
            state     <= S_RESP;
          end else begin
            run_cnt <= run_cnt + 8'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            gap_cnt   <= '0;
            state     <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_core_scheduler.sv
module tb_aes_core_scheduler;
  localparam int T = 8;
  localparam int G = 2;

  localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CH1 = 128'ha6f2daeb140fa720529e75d521cbc681;
  localparam logic [127:0] CH2 = 128'hd7b26245e8c1a3f09b4d7e21c6a58f03;

  logic         AES_clk = 1'b0;
  logic         AES_rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [127:0] req0_data, req0_key, req1_data, req1_key;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [127:0] rsp_data;
  logic         core_en;
  logic [127:0] core_data_in, core_key_in;
  logic [127:0] core_data_out = '0;
  logic         core_data_out_valid = 1'b0;
  logic         busy;

  aes_core_scheduler #(.TIMEOUT_CYC(T), .GAP_CYC(G)) dut (
    .AES_clk(AES_clk), .AES_rst_n(AES_rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key(req1_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .core_en(core_en), .core_data_in(core_data_in), .core_key_in(core_key_in),
    .core_data_out(core_data_out), .core_data_out_valid(core_data_out_valid), .busy(busy)
  );

  always #5 AES_clk = ~AES_clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Stand-in AES core: known vectors answer correctly, valid arrives on the
  // core_lat-th cycle of core_en unless the core is hung.
  int core_lat  = 3;
  bit core_hang = 1'b0;
  int en_cnt    = 0;

  function automatic logic [127:0] aes_lookup(input logic [127:0] k, input logic [127:0] d);
    if (k == K0 && d == P0) return C0;
    if (k == K1 && d == P1) return C1;
    return k ^ d;
  endfunction

  always @(posedge AES_clk) begin
    #1;
    if (core_en === 1'b1) en_cnt++;
    else en_cnt = 0;
    if (core_en === 1'b1 && !core_hang && en_cnt == core_lat) begin
      core_data_out_valid = 1'b1;
      core_data_out       = aes_lookup(core_key_in, core_data_in);
    end else begin
      core_data_out_valid = 1'b0;
      core_data_out       = {4{32'hdeadbeef}};
    end
  end

  // Behavioural model: phase 0 idle, 1 core running, 2 response, 3 gap.
  int           ph = 0;
  bit           m_last = 1'b1;
  logic         m_id, m_err, m_w;
  logic [127:0] m_data, m_key, m_rdata;
  int           m_run, m_gap;
  int           cyc = 0;
  int           en_run = 0;

  bit           grant_q[$];
  int           grant_cyc_q[$];
  logic [127:0] rsp_dq[$];
  bit           rsp_idq[$];
  bit           rsp_errq[$];
  int           rsp_cyc_q[$];
  int           en_q[$];

  always @(negedge AES_clk) begin
    cyc++;
    chk("busy", busy, ph != 0);
    chk("core_en", core_en, ph == 1);
    chk("rsp_valid", rsp_valid, ph == 2);
    chk("req0_ready", req0_ready, ph == 0 && req0_valid && (!req1_valid || m_last));
    chk("req1_ready", req1_ready, ph == 0 && req1_valid && (!req0_valid || !m_last));
    if (ph == 1) begin
      chk("core_data_in", core_data_in, m_data);
      chk("core_key_in", core_key_in, m_key);
    end
    if (ph == 2) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_err", rsp_err, m_err);
      chk("rsp_data", rsp_data, m_rdata);
    end

    if (AES_rst_n) begin
      if (req0_valid && req0_ready) begin grant_q.push_back(1'b0); grant_cyc_q.push_back(cyc); end
      if (req1_valid && req1_ready) begin grant_q.push_back(1'b1); grant_cyc_q.push_back(cyc); end
      if (rsp_valid && rsp_ready) begin
        rsp_dq.push_back(rsp_data);
        rsp_idq.push_back(rsp_id);
        rsp_errq.push_back(rsp_err);
        rsp_cyc_q.push_back(cyc);
      end
    end
    if (core_en === 1'b1) en_run++;
    else if (en_run > 0) begin en_q.push_back(en_run); en_run = 0; end

    if (!AES_rst_n) begin
      ph     = 0;
      m_last = 1'b1;
    end else begin
      case (ph)
        0: if (req0_valid || req1_valid) begin
             m_w    = (req0_valid && req1_valid) ? !m_last : req1_valid;
             m_id   = m_w;
             m_last = m_w;
             m_data = m_w ? req1_data : req0_data;
             m_key  = m_w ? req1_key  : req0_key;
             m_run  = 0;
             ph     = 1;
           end
        1: if (core_data_out_valid) begin
             m_rdata = core_data_out; m_err = 1'b0; ph = 2;
           end else if (m_run == T - 1) begin
             m_rdata = '0; m_err = 1'b1; ph = 2;
           end else m_run++;
        2: if (rsp_ready) begin ph = 3; m_gap = 0; end
        default: if (m_gap == G - 1) ph = 0; else m_gap++;
      endcase
    end
  end

  task automatic tick();
    @(posedge AES_clk);
    #1;
  endtask

  task automatic send(input bit id, input logic [127:0] d, input logic [127:0] k);
    bit got = 1'b0;
    if (id) begin req1_valid = 1'b1; req1_data = d; req1_key = k; end
    else    begin req0_valid = 1'b1; req0_data = d; req0_key = k; end
    repeat (200) begin
      @(negedge AES_clk);
      if (id ? req1_ready : req0_ready) begin got = 1'b1; break; end
    end
    chk("send_wait", got, 1'b1);
    tick();
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    bit ok = 1'b0;
    repeat (300) begin
      if (rsp_dq.size() >= n) begin ok = 1'b1; break; end
      tick();
    end
    chk("rsp_wait", ok, 1'b1);
  endtask

  task automatic wait_grant(input int n);
    bit ok = 1'b0;
    repeat (300) begin
      tick();
      if (grant_q.size() >= n) begin ok = 1'b1; break; end
    end
    chk("grant_wait", ok, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "time limit");
  end

  int r;
  int g;

  initial begin
    AES_rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_data = '0; req0_key = '0;
    req1_valid = 1'b0; req1_data = '0; req1_key = '0;
    repeat (3) tick();
    chk("rst_core_en", core_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_core_data_in", core_data_in, '0);
    AES_rst_n = 1'b1;
    tick();

    // single req0
    send(1'b0, P0, K0);
    chk("A_en_after_hs", core_en, 1'b1);
    wait_rsp(1); tick();
    chk("A_data", rsp_dq[0], C0);
    chk("A_id", rsp_idq[0], 1'b0);
    chk("A_err", rsp_errq[0], 1'b0);
    chk("A_en_len", en_q[$], 3);

    // both requesters valid continuously; req0 was served last
    r = rsp_dq.size(); g = grant_q.size();
    req0_valid = 1'b1; req0_data = P0; req0_key = K0;
    req1_valid = 1'b1; req1_data = P1; req1_key = K1;
    wait_grant(g + 4);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(r + 4);
    chk("B_g0", grant_q[g], 1'b1);
    chk("B_g1", grant_q[g+1], 1'b0);
    chk("B_g2", grant_q[g+2], 1'b1);
    chk("B_g3", grant_q[g+3], 1'b0);
    chk("B_r1_data", rsp_dq[r], C1);
    chk("B_r1_id", rsp_idq[r], 1'b1);
    chk("B_r0_data", rsp_dq[r+1], C0);

    // input churn while the core runs
    core_lat = 4; r = rsp_dq.size();
    send(1'b0, P0, K0);
    req0_data = CH1; tick();
    req0_data = CH2; req0_key = ~K0; tick();
    chk("C_hold_data", core_data_in, P0);
    wait_rsp(r + 1);
    chk("C_data", rsp_dq[r], C0);

    // core valid on the same cycle as the watchdog expiry
    core_lat = T; r = rsp_dq.size();
    send(1'b1, P1, K1);
    wait_rsp(r + 1); tick();
    chk("D_err", rsp_errq[r], 1'b0);
    chk("D_data", rsp_dq[r], C1);
    chk("D_en_len", en_q[$], T);

    // hung core
    core_hang = 1'b1; r = rsp_dq.size();
    send(1'b0, P0, K0);
    wait_rsp(r + 1); tick();
    chk("E_err", rsp_errq[r], 1'b1);
    chk("E_data", rsp_dq[r], '0);
    chk("E_en_len", en_q[$], T);
    core_hang = 1'b0; core_lat = 3;
    send(1'b1, P1, K1);
    wait_rsp(r + 2);
    chk("E_next_data", rsp_dq[r+1], C1);
    chk("E_next_err", rsp_errq[r+1], 1'b0);

    // response back-pressure
    rsp_ready = 1'b0; r = rsp_dq.size();
    send(1'b0, P0, K0);
    repeat (100) begin if (rsp_valid) break; tick(); end
    chk("F_rsp_up", rsp_valid, 1'b1);
    req1_valid = 1'b1; req1_data = P1; req1_key = K1;
    g = grant_q.size();
    repeat (10) begin
      tick();
      chk("F_stall_valid", rsp_valid, 1'b1);
      chk("F_stall_data", rsp_data, C0);
      chk("F_stall_id", rsp_id, 1'b0);
      chk("F_req1_ready", req1_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    wait_grant(g + 1);
    req1_valid = 1'b0;
    chk("F_spacing", grant_cyc_q[g] - rsp_cyc_q[r], G + 1);
    wait_rsp(r + 2);
    chk("F_r1_data", rsp_dq[r+1], C1);

    // reset in the middle of a run
    core_hang = 1'b1;
    send(1'b0, P0, K0);
    tick(); tick();
    AES_rst_n = 1'b0;
    tick();
    chk("G_core_en", core_en, 1'b0);
    chk("G_busy", busy, 1'b0);
    chk("G_rsp_valid", rsp_valid, 1'b0);
    AES_rst_n = 1'b1; core_hang = 1'b0;
    r = rsp_dq.size(); g = grant_q.size();
    req0_valid = 1'b1; req0_data = P0; req0_key = K0;
    req1_valid = 1'b1; req1_data = P1; req1_key = K1;
    wait_grant(g + 1);
    req0_valid = 1'b0;
    wait_grant(g + 2);
    req1_valid = 1'b0;
    wait_rsp(r + 2);
    chk("G_first_grant", grant_q[g], 1'b0);
    chk("G_second_grant", grant_q[g+1], 1'b1);
    chk("G_r0_data", rsp_dq[r], C0);

    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
